// File: rtl/state_trace_capture_pkg.sv
// Shared constants and types for the FSM state-trace capture block.
// A trace entry is {ts, F, S}; the FSM resets to F=0, S=001.
package state_trace_capture_pkg;

    localparam int unsigned SNAP_W   = 4;
    localparam int unsigned DEF_TS_W = 8;
    localparam int unsigned ENTRY_W  = DEF_TS_W + SNAP_W;

    localparam logic [SNAP_W-1:0] SNAP_RST = 4'b0001;

    // Field offsets inside an entry
    localparam int unsigned ENTRY_S_LSB  = 0;
    localparam int unsigned ENTRY_F_BIT  = 3;
    localparam int unsigned ENTRY_TS_LSB = 4;

    typedef struct packed {
        logic       f;
        logic [2:0] s;
    } snap_t;

    // S is {A, B, ~B}; the two low bits must always differ.
    function automatic logic s_illegal(logic [2:0] s);
        return s[0] == s[1];
    endfunction

endpackage

// File: rtl/state_trace_capture_trace_fifo.sv
// Synchronous FIFO with clear, level and full/empty flags.
// rdata_o reads as zero while empty so the output is defined after reset.
module trace_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 12
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [Width-1:0]         wdata_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(Depth):0]   level_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic             pop_ok;
    logic             push_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LvlW'(Depth));
    assign level_o = level_q;

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign pop_ok  = pop_i & ~empty_o & ~clr_i;
    assign push_ok = push_i & ~clr_i & (~full_o | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            level_d = level_q + LvlW'(push_ok) - LvlW'(pop_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/state_trace_capture.sv
// Logs every change of the sequence-detector outputs {F,S} with a timestamp,
// and keeps an F-high cycle count plus sticky overflow/illegal-encoding flags.
module state_trace_capture
    import state_trace_capture_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TS_W  = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     F,
    input  logic [2:0]               S,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [TS_W+3:0]          rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         f_count,
    output logic                     overflow,
    output logic                     illegal
);

    localparam int unsigned EntryW = TS_W + SNAP_W;

    logic [TS_W-1:0]   ts_q, ts_d;
    snap_t             prev_q, prev_d;
    logic [CNT_W-1:0]  f_count_q, f_count_d;
    logic              overflow_q, overflow_d;
    logic              illegal_q, illegal_d;

    snap_t             snap;
    logic [EntryW-1:0] entry;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;

    assign snap  = '{f: F, s: S};
    assign entry = {ts_q, snap};
    // clr suppresses logging of the sample it coincides with.
    assign push  = en & (snap != prev_q) & ~clr;
    assign pop   = rd_valid & rd_ready;

    trace_fifo #(
        .Depth (DEPTH),
        .Width (EntryW)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .clr_i   (clr),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (entry),
        .rdata_o (rd_data),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (level)
    );

    always_comb begin
        ts_d       = en ? ts_q + TS_W'(1) : ts_q;
        prev_d     = (en | clr) ? snap : prev_q;
        f_count_d  = f_count_q;
        overflow_d = overflow_q;
        illegal_d  = illegal_q;
        if (clr) begin
            f_count_d  = '0;
            overflow_d = 1'b0;
            illegal_d  = 1'b0;
        end else begin
            if (en & F & (f_count_q != {CNT_W{1'b1}})) f_count_d = f_count_q + CNT_W'(1);
            if (push & fifo_full & ~pop)                overflow_d = 1'b1;
            if (en & s_illegal(S))                      illegal_d  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ts_q       <= '0;
            prev_q     <= SNAP_RST;
            f_count_q  <= '0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            prev_q     <= prev_d;
            f_count_q  <= f_count_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
        end
    end

    assign rd_valid = ~fifo_empty;
    assign f_count  = f_count_q;
    assign overflow = overflow_q;
    assign illegal  = illegal_q;

endmodule
